// File: rtl/icache_responder.sv
// rtl/icache_responder.sv - direct-mapped read-only instruction cache responder
// Zero-cycle hits; a miss stalls fetch and refills one 128-bit line over mem_read/mem_ready.
module icache_responder #(
  parameter int          NUM_LINES = 8,
  parameter logic [31:0] RESET_NOP = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         proc_read,
  input  logic [31:0]  proc_addr,
  output logic [31:0]  proc_rdata,
  output logic         proc_stall,
  output logic         mem_read,
  output logic [27:0]  mem_addr,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic {S_IDLE, S_MISS} state_t;

  state_t               r_state;
  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [127:0]         r_data [NUM_LINES];
  logic                 r_mem_read;
  logic [27:0]          r_mem_addr;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_fill_idx;
  logic [TAG_W-1:0] w_fill_tag;
  logic             w_fill;
  logic             w_hit;
  logic [127:0]     w_line;
  logic [31:0]      w_word;
  logic             w_unused;

  assign w_idx      = proc_addr[3+IDX_W:4];
  assign w_tag      = proc_addr[31:4+IDX_W];
  // Refill targets the latched request, so a fetch that misbehaves while stalled cannot redirect it.
  assign w_fill_idx = r_mem_addr[IDX_W-1:0];
  assign w_fill_tag = r_mem_addr[27:IDX_W];
  assign w_fill     = (r_state == S_MISS) && mem_ready;
  assign w_unused   = &{1'b0, proc_addr[1:0]};

  assign w_hit  = proc_read && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_line = r_data[w_idx];

  always_comb begin
    w_word = w_line[31:0];
    case (proc_addr[3:2])
      2'd0: w_word = w_line[31:0];
      2'd1: w_word = w_line[63:32];
      2'd2: w_word = w_line[95:64];
      2'd3: w_word = w_line[127:96];
      default: w_word = w_line[31:0];
    endcase
  end

  assign proc_stall = !rst && ((r_state == S_MISS) || (proc_read && !w_hit));
  assign proc_rdata = (!rst && (r_state == S_IDLE) && w_hit) ? w_word : RESET_NOP;
  assign mem_read   = r_mem_read;
  assign mem_addr   = r_mem_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_valid    <= '0;
      r_mem_read <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (proc_read && !w_hit) begin
            r_state    <= S_MISS;
            r_mem_read <= 1'b1;
            r_mem_addr <= proc_addr[31:4];
          end
        end
        S_MISS: begin
          if (mem_ready) begin
            r_valid[w_fill_idx] <= 1'b1;
            r_mem_read          <= 1'b0;
            r_state             <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[w_fill_idx] <= mem_rdata;
      r_tag[w_fill_idx]  <= w_fill_tag;
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
// tb/tb_icache_responder.sv - randomized self-checking bench for icache_responder
// Reference model tracks which line address occupies each cache slot; memory content is a pure function.
module tb_icache_responder;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         proc_read = 1'b0;
  logic [31:0]  proc_addr = '0;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic [27:0]  mem_addr;
  logic [127:0] mem_rdata = '0;
  logic         mem_ready = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  logic        m_valid [8];
  logic [27:0] m_line  [8];

  icache_responder #(.NUM_LINES(8), .RESET_NOP(NOP)) dut (
    .clk(clk), .rst(rst), .proc_read(proc_read), .proc_addr(proc_addr),
    .proc_rdata(proc_rdata), .proc_stall(proc_stall), .mem_read(mem_read),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  logic        p_stall = 1'b0;
  logic        p_read  = 1'b0;
  logic [31:0] p_addr  = '0;
  always @(posedge clk) begin
    if (!rst && p_stall && p_read && proc_read)
      assert (proc_addr == p_addr) else $error("protocol: proc_addr moved while stalled");
    p_stall <= proc_stall;
    p_read  <= proc_read;
    p_addr  <= proc_addr;
  end

  function automatic logic [127:0] mem_line(input logic [27:0] la);
    logic [127:0] r;
    for (int k = 0; k < 4; k++)
      r[32*k +: 32] = 32'h0010_0093 + 32'(k) * 32'h0010_0000 + {4'h0, la} * 32'h0000_1001;
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_line[i]  = '0;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    proc_read = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  // One fetch starting at a negedge; ends at a negedge with the fetch retired.
  task automatic do_fetch(input logic [31:0] a, input int lat, input bit drop, input bit stray);
    logic [27:0]  la;
    logic [127:0] ln;
    logic [31:0]  w;
    int           idx;
    la  = a[31:4];
    idx = int'(la[2:0]);
    ln  = mem_line(la);
    w   = ln[32*int'(a[3:2]) +: 32];
    proc_read = 1'b1;
    proc_addr = a;
    mem_ready = stray;
    mem_rdata = ~ln;
    #1;
    if (m_valid[idx] && m_line[idx] == la) begin
      n_cmp++;
      if (proc_stall !== 1'b0 || proc_rdata !== w || mem_read !== 1'b0) begin
        n_err++;
        $display("FAIL hit a=%h: stall=%b rdata=%h mem_read=%b, required stall=0 rdata=%h mem_read=0",
                 a, proc_stall, proc_rdata, mem_read, w);
      end
      @(negedge clk);
      mem_ready = 1'b0;
    end else begin
      n_cmp++;
      if (proc_stall !== 1'b1 || proc_rdata !== NOP || mem_read !== 1'b0) begin
        n_err++;
        $display("FAIL miss_detect a=%h: stall=%b rdata=%h mem_read=%b, required 1/%h/0",
                 a, proc_stall, proc_rdata, mem_read, NOP);
      end
      for (int c = 1; c <= lat; c++) begin
        @(negedge clk);
        mem_ready = 1'b0;
        if (drop) proc_read = 1'b0;
        if (c == lat) begin
          mem_ready = 1'b1;
          mem_rdata = ln;
        end
        #1;
        n_cmp++;
        if (proc_stall !== 1'b1 || mem_read !== 1'b1 || mem_addr !== la || proc_rdata !== NOP) begin
          n_err++;
          $display("FAIL refill a=%h cyc=%0d: stall=%b mem_read=%b mem_addr=%h rdata=%h, required 1/1/%h/%h",
                   a, c, proc_stall, mem_read, mem_addr, proc_rdata, la, NOP);
        end
      end
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = '0;
      m_valid[idx] = 1'b1;
      m_line[idx]  = la;
      #1;
      n_cmp++;
      if (proc_stall !== 1'b0 || mem_read !== 1'b0 || proc_rdata !== (drop ? NOP : w)) begin
        n_err++;
        $display("FAIL after_refill a=%h: stall=%b mem_read=%b rdata=%h, required 0/0/%h",
                 a, proc_stall, mem_read, proc_rdata, drop ? NOP : w);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    proc_read = 1'b1;
    proc_addr = 32'h0;
    #1;
    n_cmp++;
    if (proc_stall !== 1'b0 || proc_rdata !== NOP || mem_read !== 1'b0 || mem_addr !== 28'h0) begin
      n_err++;
      $display("FAIL reset_state: stall=%b rdata=%h mem_read=%b mem_addr=%h, required 0/%h/0/0",
               proc_stall, proc_rdata, mem_read, mem_addr, NOP);
    end
    apply_reset();
  endtask

  task automatic test_cold_miss_and_hits();
    do_fetch(32'h0000_0000, 5, 1'b0, 1'b0);
    do_fetch(32'h0000_0004, 1, 1'b0, 1'b0);
    do_fetch(32'h0000_0008, 1, 1'b0, 1'b0);
    do_fetch(32'h0000_000C, 1, 1'b0, 1'b0);
    n_cmp++;
    if (mem_line(28'h0) !== {32'h0040_0093, 32'h0030_0093, 32'h0020_0093, 32'h0010_0093}) begin
      n_err++;
      $display("FAIL line0_pattern: model line %h", mem_line(28'h0));
    end
  endtask

  task automatic test_conflict();
    do_fetch(32'h0000_0080, 3, 1'b0, 1'b0);
    do_fetch(32'h0000_0000, 2, 1'b0, 1'b0);
    do_fetch(32'h0000_0084, 2, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_refill();
    apply_reset();
    proc_read = 1'b1;
    proc_addr = 32'h0;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (mem_read !== 1'b1 || proc_stall !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_refill: mem_read=%b stall=%b, required 1/1", mem_read, proc_stall);
    end
    rst = 1'b1;
    proc_read = 1'b0;
    #1;
    n_cmp++;
    if (mem_read !== 1'b0 || proc_stall !== 1'b0 || proc_rdata !== NOP) begin
      n_err++;
      $display("FAIL reset_mid_miss: mem_read=%b stall=%b rdata=%h, required 0/0/%h",
               mem_read, proc_stall, proc_rdata, NOP);
    end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    mem_ready = 1'b1;
    mem_rdata = mem_line(28'h0);
    #1;
    n_cmp++;
    if (mem_read !== 1'b0 || proc_stall !== 1'b0) begin
      n_err++;
      $display("FAIL stray_ready: mem_read=%b stall=%b, required 0/0", mem_read, proc_stall);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    do_fetch(32'h0000_0000, 2, 1'b0, 1'b0);
  endtask

  task automatic test_drop_and_idle();
    do_fetch(32'h0000_0010, 3, 1'b1, 1'b0);
    do_fetch(32'h0000_0014, 1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      proc_read = 1'b0;
      proc_addr = $urandom;
      mem_ready = 1'(i & 1);
      #1;
      n_cmp++;
      if (proc_stall !== 1'b0 || proc_rdata !== NOP || mem_read !== 1'b0) begin
        n_err++;
        $display("FAIL idle a=%h: stall=%b rdata=%h mem_read=%b, required 0/%h/0",
                 proc_addr, proc_stall, proc_rdata, mem_read, NOP);
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;
    do_fetch(32'h0000_0018, 1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [24:0] tags [4];
    tags[0] = 25'h0;
    tags[1] = 25'h1;
    tags[2] = 25'h1FF_FFFF;
    tags[3] = 25'h123_4567;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = {tags[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 4'($urandom)};
      do_fetch(a, int'($urandom_range(1, 4)), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 5) == 0));
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_cold_miss_and_hits();
    test_conflict();
    test_reset_mid_refill();
    test_drop_and_idle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
